hahaha_cpu: RTL and testbench
=============================

# hahaha_cpu

Single-cycle, word-addressed mini-MIPS processor core, the top of the IITK mini-MIPS design. Each clock edge retires one 32-bit MIPS-format instruction fetched from an internal instruction ROM. It contains a 32×32 register file with HI/LO and a word-addressed data RAM. There are no external data ports: state is observed hierarchically.

## Interface
- IMEM_DEPTH, 256: instruction ROM words.
- DMEM_DEPTH, 256: data RAM words.
- IMEM_FILE, "imem.hex": hex image loaded into the ROM at elaboration.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- Required hierarchical names, probed by benches:
  - `instruction[31:0]`: current fetched word.
  - `PC[31:0]`: word index.
  - `uu1.GPR[0:31]`, `uu1.hi`, `uu1.lo`.
  - `data_memory.mem[0:DMEM_DEPTH-1]`.

## Operation
- Fetch: `instruction = imem[PC mod IMEM_DEPTH]`, combinational.
- Decode fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
  - Immediate is sign-extended unless noted.
- R-type (op 0x00), dest rd:
  - add 0x20 and addu 0x21: wrap-around, no overflow trap.
  - sub 0x22, and 0x24, or 0x25, xor 0x26.
  - slt 0x2A: signed compare; sltu 0x2B: unsigned compare.
  - sll 0x00 and srl 0x02: shift rt by shamt.
  - jr 0x08: PC ← rs.
- I-type, dest rt:
  - addi 0x08.
  - andi 0x0C, ori 0x0D: zero-extended immediate.
  - lui 0x0F: rt ← {imm,16'h0}.
- Memory:
  - lw 0x23: rt ← mem[(rs+sext(imm)) mod DMEM_DEPTH].
  - sw 0x2B: mem[(rs+sext(imm)) mod DMEM_DEPTH] ← rt.
  - Addresses are word indices, not byte addresses.
- Control flow:
  - beq 0x04 / bne 0x05: taken → PC ← PC+1+sext(imm).
  - j 0x02: PC ← {PC[31:26], target}.
- Otherwise PC ← PC+1, wrapping at 2³².
- GPR[0] reads 0; writes to it are discarded.
- Unlisted opcodes and functs execute as NOP: no state change except PC+1.

## Timing
- Single cycle: every architectural write commits on the same rising edge, and the next instruction is visible after that edge. CPI = 1.
- Register reads are combinational. Within one edge, a read sees the pre-edge value: no intra-cycle forwarding.
- rst high at a rising edge clears:
  - PC, all GPR, hi and lo to 0.
  - All data RAM words to 0.
  - The instruction ROM is untouched.
- Reset asserted mid-program: the current instruction's writes are suppressed and the reset values win.
- rst has no asynchronous effect; before the first rising edge, state is whatever the simulator gives it.
- After rst falls, the first instruction (imem[0]) retires on the first rising edge with rst low.

## Configuration
- HAHAHA_MULT_EN defined: adds R-type multiply and HI/LO moves.
  - mult 0x18 (signed) and multu 0x19: {hi,lo} ← rs×rt, 64-bit product.
  - mfhi 0x10, mflo 0x12: rd ← hi / lo.
  - mthi 0x11, mtlo 0x13: hi / lo ← rs.
- Not defined:
  - Those functs are NOPs.
  - hi and lo still exist and stay 0, so hierarchical probes remain legal.

## Structure
- Shared package `hahaha_pkg`:
  - Opcode and funct localparams.
  - An ALU-op enum.
  - Field-extraction widths.
- One natural sub-module, `hahaha_regfile`, instantiated as `uu1`:
  - GPR array with hi/lo.
  - Two combinational read ports and one write port.
  - A hi/lo write port.
  - Synchronous reset clear.
- Data RAM is an instance named `data_memory`:
  - Single-port, synchronous write, combinational read.
  - Inline module or a simple RAM module.
- ALU and decode stay in the top.

## Test plan
- Reset, then 5 straight-line NOP/ALU instructions with rst released: at 1 ns after the 5th post-reset edge, PC = 5 and `instruction` = imem[5].
- lui r11,1000; ori r11,r11,0x1234; add r3,r1,r2 with r1=5, r2=7 → GPR[11] = 0x03E81234, GPR[3] = 12; add r0,r1,r2 leaves GPR[0] = 0.
- addi r1,r0,1; addi r2,r0,0xABCD; sw r1-base: sw r2,2(r1) → mem[3] = 0xFFFFABCD; lw r4,2(r1) → GPR[4] = 0xFFFFABCD.
- beq r0,r0,-1 at PC 4 → PC stays 4 every cycle. bne r0,r0,+3 → PC+1. j 0x10 → PC = 16.
- With HAHAHA_MULT_EN: r1 = -3, r2 = 4, mult r1,r2 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF4; mflo r5 → GPR[5] = 0xFFFFFFF4. Without the macro: hi = lo = 0 and GPR[5] unchanged.
- Assert rst for one edge mid-program after writes → PC, GPR[1..31], hi, lo and mem all 0. Execution restarts at imem[0] on the next edge.

Source files
------------

// File: rtl/hahaha_pkg.sv
// Shared definitions for the hahaha_cpu mini-MIPS core: opcodes, functs,
// field widths, ALU operations and write-back source selection.
package hahaha_pkg;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int TGT_W   = 26;
  localparam int XLEN    = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_JR    = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_HI, WB_LO} wb_sel_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/hahaha_dmem.sv
// Word-addressed single-port data RAM: synchronous write, combinational read,
// whole-array synchronous clear on reset.
module hahaha_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);

  logic [31:0] mem [0:DEPTH-1];

  assign rd_o = mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we_i) begin
      mem[addr_i] <= wd_i;
    end
  end

endmodule

// File: rtl/hahaha_regfile.sv
// 32x32 general-purpose register file plus HI/LO, two combinational read
// ports, one GPR write port and a HI/LO write port; synchronous reset clear.
module hahaha_regfile
  import hahaha_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ra1_i,
  input  logic [REG_W-1:0] ra2_i,
  output logic [XLEN-1:0]  rd1_o,
  output logic [XLEN-1:0]  rd2_o,
  input  logic             we_i,
  input  logic [REG_W-1:0] wa_i,
  input  logic [XLEN-1:0]  wd_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [XLEN-1:0]  hi_wd_i,
  input  logic [XLEN-1:0]  lo_wd_i,
  output logic [XLEN-1:0]  hi_o,
  output logic [XLEN-1:0]  lo_o
);

  logic [XLEN-1:0] GPR [0:31];
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // r0 is forced to read zero even before the first reset.
  assign rd1_o = (ra1_i == '0) ? '0 : GPR[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : GPR[ra2_i];
  assign hi_o  = hi;
  assign lo_o  = lo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) GPR[i] <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (we_i && (wa_i != '0)) GPR[wa_i] <= wd_i;
      if (hi_we_i) hi <= hi_wd_i;
      if (lo_we_i) lo <= lo_wd_i;
    end
  end

endmodule

// File: rtl/hahaha_cpu.sv
// Single-cycle word-addressed mini-MIPS core with internal ROM and data RAM.
// Define HAHAHA_MULT_EN to enable mult/multu and the HI/LO move instructions.
module hahaha_cpu
  import hahaha_pkg::*;
#(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input  logic clk,
  input  logic rst
);

  // Depths are assumed to be powers of two, so truncation implements the modulo.
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] imem [0:IMEM_DEPTH-1];

  logic [XLEN-1:0]    PC;
  logic [XLEN-1:0]    pc_d;
  logic [XLEN-1:0]    pc_plus1;
  logic [XLEN-1:0]    instruction;

  logic [OP_W-1:0]    op;
  logic [REG_W-1:0]   rs, rt, rd;
  logic [SHAMT_W-1:0] shamt;
  logic [FUNCT_W-1:0] funct;
  logic [IMM_W-1:0]   imm;
  logic [TGT_W-1:0]   target;
  logic [XLEN-1:0]    imm_sext, imm_zext;

  logic [XLEN-1:0]    rs_val, rt_val, hi_val, lo_val;
  logic [XLEN-1:0]    alu_b, alu_y, wb_data, dmem_rd;
  logic [DAW-1:0]     dmem_addr;
  alu_op_e            alu_op;
  wb_sel_e            wb_sel;
  logic               wb_en, mem_we, hi_we, lo_we;
  logic [REG_W-1:0]   wb_addr;
  logic [XLEN-1:0]    hi_wd, lo_wd;

  assign instruction = imem[IAW'(PC)];
  assign pc_plus1    = PC + 32'd1;

  assign op       = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign shamt    = instruction[10:6];
  assign funct    = instruction[5:0];
  assign imm      = instruction[15:0];
  assign target   = instruction[25:0];
  assign imm_sext = sext_imm(imm);
  assign imm_zext = {{(XLEN-IMM_W){1'b0}}, imm};

  assign dmem_addr = DAW'(rs_val + imm_sext);

`ifdef HAHAHA_MULT_EN
  logic [2*XLEN-1:0] prod_s, prod_u;
  assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
  assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
`endif

  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rt_val;
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_sel  = WB_ALU;
    mem_we  = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_wd   = hi_val;
    lo_wd   = lo_val;
    pc_d    = pc_plus1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  wb_en = 1'b1; end
          FN_SUB:          begin alu_op = ALU_SUB;  wb_en = 1'b1; end
          FN_AND:          begin alu_op = ALU_AND;  wb_en = 1'b1; end
          FN_OR:           begin alu_op = ALU_OR;   wb_en = 1'b1; end
          FN_XOR:          begin alu_op = ALU_XOR;  wb_en = 1'b1; end
          FN_SLT:          begin alu_op = ALU_SLT;  wb_en = 1'b1; end
          FN_SLTU:         begin alu_op = ALU_SLTU; wb_en = 1'b1; end
          FN_SLL:          begin alu_op = ALU_SLL;  wb_en = 1'b1; end
          FN_SRL:          begin alu_op = ALU_SRL;  wb_en = 1'b1; end
          FN_JR:           pc_d = rs_val;
`ifdef HAHAHA_MULT_EN
          FN_MULT:  begin hi_we = 1'b1; lo_we = 1'b1; {hi_wd, lo_wd} = prod_s; end
          FN_MULTU: begin hi_we = 1'b1; lo_we = 1'b1; {hi_wd, lo_wd} = prod_u; end
          FN_MFHI:  begin wb_en = 1'b1; wb_sel = WB_HI; end
          FN_MFLO:  begin wb_en = 1'b1; wb_sel = WB_LO; end
          FN_MTHI:  begin hi_we = 1'b1; hi_wd = rs_val; end
          FN_MTLO:  begin lo_we = 1'b1; lo_wd = rs_val; end
`else
          FN_MULT, FN_MULTU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: ;
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin alu_b = imm_sext; wb_addr = rt; wb_en = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OP_LUI:  begin alu_op = ALU_LUI; wb_addr = rt; wb_en = 1'b1; end
      OP_LW:   begin wb_sel = WB_MEM;  wb_addr = rt; wb_en = 1'b1; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus1 + imm_sext;
      OP_BNE:  if (rs_val != rt_val) pc_d = pc_plus1 + imm_sext;
      OP_J:    pc_d = {PC[31:26], target};
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_XOR:  alu_y = rs_val ^ alu_b;
      ALU_SLT:  alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'h0, rs_val < alu_b};
      ALU_SLL:  alu_y = rt_val << shamt;
      ALU_SRL:  alu_y = rt_val >> shamt;
      ALU_LUI:  alu_y = {imm, 16'h0};
      default:  alu_y = rs_val + alu_b;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rd;
      WB_HI:   wb_data = hi_val;
      WB_LO:   wb_data = lo_val;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) PC <= '0;
    else     PC <= pc_d;
  end

  hahaha_regfile uu1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .ra1_i   (rs),
    .ra2_i   (rt),
    .rd1_o   (rs_val),
    .rd2_o   (rt_val),
    .we_i    (wb_en),
    .wa_i    (wb_addr),
    .wd_i    (wb_data),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .hi_wd_i (hi_wd),
    .lo_wd_i (lo_wd),
    .hi_o    (hi_val),
    .lo_o    (lo_val)
  );

  hahaha_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) data_memory (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (mem_we),
    .addr_i (dmem_addr),
    .wd_i   (rt_val),
    .rd_o   (dmem_rd)
  );

endmodule

// File: tb/tb_hahaha_cpu.sv
// Self-checking bench for hahaha_cpu: programs are poked into the ROM and
// architectural state is probed hierarchically against a scoreboard queue.
module tb_hahaha_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hahaha_cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .IMEM_FILE("")) dut (
    .clk (clk),
    .rst (rst)
  );

  localparam int K_PC = 0, K_INSTR = 1, K_GPR = 2, K_MEM = 3, K_HI = 4, K_LO = 5,
                 K_GPR_NZ = 6, K_MEM_NZ = 7;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog [0:255];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] rtype(int fn, int rs, int rt, int rd, int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] probe(int kind, int idx);
    int n;
    n = 0;
    case (kind)
      K_PC:    return dut.PC;
      K_INSTR: return dut.instruction;
      K_GPR:   return dut.uu1.GPR[idx];
      K_MEM:   return dut.data_memory.mem[idx];
      K_HI:    return dut.uu1.hi;
      K_LO:    return dut.uu1.lo;
      K_GPR_NZ: begin
        for (int i = 1; i < 32; i++) if (dut.uu1.GPR[i] !== 32'h0) n++;
        return 32'(n);
      end
      K_MEM_NZ: begin
        for (int i = 0; i < 256; i++) if (dut.data_memory.mem[i] !== 32'h0) n++;
        return 32'(n);
      end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(string name, int kind, int idx, logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic load_and_reset();
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    clear_prog();
    prog[0] = itype(8'h08, 0, 1, 1);
    prog[1] = itype(8'h08, 0, 2, 2);
    prog[3] = rtype(8'h25, 1, 2, 3, 0);
    prog[5] = itype(8'h08, 0, 9, 8'h55);
    load_and_reset();
    push("rst_pc", K_PC, 0, 32'd0);
    push("rst_instr", K_INSTR, 0, prog[0]);
    push("rst_gpr_nz", K_GPR_NZ, 0, 32'd0);
    push("rst_mem_nz", K_MEM_NZ, 0, 32'd0);
    push("rst_hi", K_HI, 0, 32'd0);
    push("rst_lo", K_LO, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
    push("straight_pc", K_PC, 0, 32'd5);
    push("straight_instr", K_INSTR, 0, prog[5]);
    push("straight_or_r3", K_GPR, 3, 32'd3);
    step(5);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  task automatic test_alu();
    exp_t e;
    logic [31:0] obs;
    clear_prog();
    prog[0]  = itype(8'h08, 0, 1, 5);
    prog[1]  = itype(8'h08, 0, 2, 7);
    prog[2]  = itype(8'h0F, 0, 11, 1000);
    prog[3]  = itype(8'h0D, 11, 11, 16'h1234);
    prog[4]  = rtype(8'h20, 1, 2, 3, 0);
    prog[5]  = rtype(8'h20, 1, 2, 0, 0);
    prog[6]  = rtype(8'h22, 1, 2, 4, 0);
    prog[7]  = rtype(8'h2A, 4, 1, 5, 0);
    prog[8]  = rtype(8'h2B, 4, 1, 6, 0);
    prog[9]  = rtype(8'h00, 0, 1, 7, 4);
    prog[10] = rtype(8'h02, 0, 4, 8, 28);
    prog[11] = rtype(8'h26, 1, 2, 9, 0);
    prog[12] = rtype(8'h24, 1, 2, 10, 0);
    prog[13] = itype(8'h0C, 4, 12, 16'hFF00);
    prog[14] = itype(8'h08, 0, 13, -1);
    prog[15] = rtype(8'h21, 13, 1, 14, 0);
    load_and_reset();
    push("lui_ori_r11", K_GPR, 11, 32'h03E8_1234);
    push("add_r3", K_GPR, 3, 32'd12);
    push("r0_discard", K_GPR, 0, 32'd0);
    push("sub_r4", K_GPR, 4, 32'hFFFF_FFFE);
    push("slt_r5", K_GPR, 5, 32'd1);
    push("sltu_r6", K_GPR, 6, 32'd0);
    push("sll_r7", K_GPR, 7, 32'h50);
    push("srl_r8", K_GPR, 8, 32'hF);
    push("xor_r9", K_GPR, 9, 32'd2);
    push("and_r10", K_GPR, 10, 32'd5);
    push("andi_zext_r12", K_GPR, 12, 32'h0000_FF00);
    push("addi_neg_r13", K_GPR, 13, 32'hFFFF_FFFF);
    push("addu_wrap_r14", K_GPR, 14, 32'd4);
    step(16);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  task automatic test_mem();
    exp_t e;
    logic [31:0] obs;
    clear_prog();
    prog[0] = itype(8'h08, 0, 1, 1);
    prog[1] = itype(8'h08, 0, 2, 16'hABCD);
    prog[2] = itype(8'h2B, 1, 2, 2);
    prog[3] = itype(8'h23, 1, 4, 2);
    prog[4] = itype(8'h08, 0, 5, 3);
    prog[5] = itype(8'h2B, 0, 5, -4);
    prog[6] = itype(8'h23, 0, 6, -4);
    load_and_reset();
    push("sw_mem3", K_MEM, 3, 32'hFFFF_ABCD);
    push("lw_r4", K_GPR, 4, 32'hFFFF_ABCD);
    push("sw_wrap_mem252", K_MEM, 252, 32'd3);
    push("lw_wrap_r6", K_GPR, 6, 32'd3);
    step(7);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [31:0] obs;
    int trace [9] = '{1, 2, 3, 16, 19, 20, 30, 30, 30};
    clear_prog();
    prog[0]  = itype(8'h08, 0, 1, 1);
    prog[1]  = itype(8'h05, 0, 0, 3);
    prog[2]  = itype(8'h04, 1, 0, 5);
    prog[3]  = {6'h02, 26'h10};
    prog[16] = itype(8'h05, 1, 0, 2);
    prog[19] = itype(8'h08, 0, 2, 30);
    prog[20] = rtype(8'h08, 2, 0, 0, 0);
    prog[30] = itype(8'h04, 0, 0, -1);
    load_and_reset();
    for (int i = 0; i < 9; i++) begin
      push($sformatf("pc_trace_%0d", i), K_PC, 0, 32'(trace[i]));
      step(1);
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  task automatic test_mult();
    exp_t e;
    logic [31:0] obs;
    clear_prog();
    prog[0] = itype(8'h08, 0, 1, -3);
    prog[1] = itype(8'h08, 0, 2, 4);
    prog[2] = itype(8'h08, 0, 5, 8'h77);
    prog[3] = rtype(8'h18, 1, 2, 0, 0);
    prog[4] = rtype(8'h12, 0, 0, 5, 0);
    prog[5] = rtype(8'h10, 0, 0, 6, 0);
    prog[6] = rtype(8'h19, 1, 2, 0, 0);
    prog[7] = rtype(8'h10, 0, 0, 7, 0);
    prog[8] = rtype(8'h11, 2, 0, 0, 0);
    prog[9] = rtype(8'h13, 1, 0, 0, 0);
    load_and_reset();
`ifdef HAHAHA_MULT_EN
    push("mult_hi", K_HI, 0, 32'hFFFF_FFFF);
    push("mult_lo", K_LO, 0, 32'hFFFF_FFF4);
`else
    push("mult_hi", K_HI, 0, 32'h0);
    push("mult_lo", K_LO, 0, 32'h0);
`endif
    step(4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
`ifdef HAHAHA_MULT_EN
    push("mflo_r5", K_GPR, 5, 32'hFFFF_FFF4);
    push("mfhi_r6", K_GPR, 6, 32'hFFFF_FFFF);
    push("multu_mfhi_r7", K_GPR, 7, 32'd3);
    push("mthi_hi", K_HI, 0, 32'd4);
    push("mtlo_lo", K_LO, 0, 32'hFFFF_FFFD);
`else
    push("mflo_r5", K_GPR, 5, 32'h77);
    push("mfhi_r6", K_GPR, 6, 32'h0);
    push("multu_mfhi_r7", K_GPR, 7, 32'h0);
    push("mthi_hi", K_HI, 0, 32'h0);
    push("mtlo_lo", K_LO, 0, 32'h0);
`endif
    step(6);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] obs;
    clear_prog();
    prog[0] = itype(8'h08, 0, 1, 1);
    prog[1] = itype(8'h08, 0, 2, 16'hABCD);
    prog[2] = itype(8'h2B, 1, 2, 2);
    prog[3] = rtype(8'h18, 1, 2, 0, 0);
    prog[4] = itype(8'h08, 0, 3, 9);
    prog[5] = itype(8'h2B, 0, 3, 5);
    load_and_reset();
    push("pre_rst_mem3", K_MEM, 3, 32'hFFFF_ABCD);
`ifdef HAHAHA_MULT_EN
    push("pre_rst_lo", K_LO, 0, 32'hFFFF_ABCD);
`else
    push("pre_rst_lo", K_LO, 0, 32'h0);
`endif
    step(4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push("mid_rst_pc", K_PC, 0, 32'd0);
    push("mid_rst_gpr_nz", K_GPR_NZ, 0, 32'd0);
    push("mid_rst_mem_nz", K_MEM_NZ, 0, 32'd0);
    push("mid_rst_hi", K_HI, 0, 32'd0);
    push("mid_rst_lo", K_LO, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
    push("restart_pc", K_PC, 0, 32'd1);
    push("restart_r1", K_GPR, 1, 32'd1);
    push("restart_r3_clear", K_GPR, 3, 32'd0);
    step(1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = probe(e.kind, e.idx); checks++;
      if (obs !== e.val) begin
        $display("FAIL %s actual=%h expected=%h", e.name, obs, e.val); failures++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_mult();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
